// File: rtl/minmax_reduce_ctrl.sv
// Multi-cycle min/max reduction engine: streams len elements through one running compare and returns the extreme value.
// Optional MINMAX_REDUCE_INDEX_EN adds out_index, the zero-based position of the winning element.
module minmax_reduce_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              control,
  input  logic              sign_control,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_empty,
`ifdef MINMAX_REDUCE_INDEX_EN
  output logic [CNT_W-1:0]  out_index,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_acc;
  logic                r_max;
  logic                r_signed;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_empty;
  logic                r_busy;
`ifdef MINMAX_REDUCE_INDEX_EN
  logic [CNT_W-1:0]    r_pos;
  logic [CNT_W-1:0]    r_idx;
`endif

  logic                w_beat;
  logic                w_last;
  logic                w_gt;
  logic                w_lt;
  logic                w_win;

  // Strict compare only: equal candidates never displace acc, so ties keep the earliest element.
  always_comb begin
    w_gt = r_signed ? ($signed(in_data) > $signed(r_acc)) : (in_data > r_acc);
    w_lt = r_signed ? ($signed(in_data) < $signed(r_acc)) : (in_data < r_acc);
    w_win = r_max ? w_gt : w_lt;
  end

  assign w_beat = in_valid & r_in_ready;
  assign w_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_max       <= 1'b0;
      r_signed    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_empty     <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MINMAX_REDUCE_INDEX_EN
      r_pos       <= '0;
      r_idx       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= len;
            r_max    <= control;
            r_signed <= sign_control;
            r_busy   <= 1'b1;
            if (len == '0) begin
              r_acc       <= '0;
              r_empty     <= 1'b1;
              r_out_valid <= 1'b1;
`ifdef MINMAX_REDUCE_INDEX_EN
              r_idx       <= '0;
`endif
              r_state     <= S_DONE;
            end else begin
              r_empty    <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= S_FIRST;
            end
          end
        end
        S_FIRST: begin
          if (w_beat) begin
            r_acc <= in_data;
            r_cnt <= r_cnt - CNT_W'(1);
`ifdef MINMAX_REDUCE_INDEX_EN
            r_idx <= '0;
            r_pos <= CNT_W'(1);
`endif
            if (w_last) begin
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_beat) begin
            if (w_win) begin
              r_acc <= in_data;
`ifdef MINMAX_REDUCE_INDEX_EN
              r_idx <= r_pos;
`endif
            end
            r_cnt <= r_cnt - CNT_W'(1);
`ifdef MINMAX_REDUCE_INDEX_EN
            r_pos <= r_pos + CNT_W'(1);
`endif
            if (w_last) begin
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Result registers are untouched here, so they hold while the consumer stalls.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_acc;
  assign out_empty  = r_empty;
  assign busy       = r_busy;
`ifdef MINMAX_REDUCE_INDEX_EN
  assign out_index  = r_idx;
`endif

endmodule

// File: doc/minmax_reduce_ctrl.md
Name: minmax_reduce_ctrl

Overview:
- Sequencer that streams a vector of N 32-bit elements through a single running min/max comparison and returns the reduced extreme value.
- Sits beside the ALU as a multi-cycle reduction engine for a vector/custom instruction: the core issues start + length + mode, streams operands, then collects one result.
- Owns the accumulator register, the element counter and the valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, element and result width.
- CNT_W, 16, width of the length field and element counter; maximum vector length is 2^CNT_W-1.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a reduction; sampled only in IDLE.
- len  in  CNT_W  number of elements; sampled with start.
- control  in  1  0 = minimum, 1 = maximum; sampled with start.
- sign_control  in  1  0 = unsigned, 1 = signed compare; sampled with start.
- in_valid  in  1  element stream valid.
- in_ready  out  1  controller can accept an element.
- in_data  in  DATA_W  element value.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  reduced min/max value.
- out_empty  out  1  result is for a len = 0 request.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high. On rst: state = IDLE, in_ready = 0, out_valid = 0, out_result = 0, out_empty = 0, busy = 0, counter = 0, latched mode = 0. A rst asserted mid-reduction aborts it. No partial result is emitted, and elements in flight are dropped.
- States: IDLE, FIRST, ACCUM, DONE.
- IDLE: in_ready = 0.
  - On start, latch len, control and sign_control, and load counter = len.
  - len = 0: go to DONE with out_result = 0 and out_empty = 1.
  - Otherwise go to FIRST with out_empty = 0.
- FIRST: in_ready = 1. On an accepted beat (in_valid & in_ready), acc <= in_data and counter decrements.
  - Counter reaches 0 (len = 1): go to DONE.
  - Otherwise go to ACCUM.
- ACCUM: in_ready = 1. On an accepted beat, acc is replaced by in_data only when the candidate strictly wins:
  - Max mode: candidate > acc. Min mode: candidate < acc.
  - Signed compare when the latched sign_control = 1, unsigned otherwise.
  - Equal values keep acc.
  - Counter decrements on each accepted beat. After the beat that brings it to 0, go to DONE.
- DONE: out_valid = 1, out_result = acc (or 0 for the empty case), in_ready = 0.
  - out_result and out_empty hold stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE and drop out_valid the next cycle.
- Latency: out_valid rises in the cycle after the last element is accepted, and in the cycle after start for len = 0. Throughput is one element per clock when in_valid is held high.
- start outside IDLE is ignored. Mode inputs are don't-care outside the start cycle.
- A new start may be accepted in the first cycle back in IDLE, with no bubble requirement beyond that.
- in_data is ignored whenever in_ready = 0. The block never drives in_ready and out_valid high in the same cycle.
- The compare is purely combinational on acc and in_data. acc is DATA_W wide and has no width growth.

Optional Feature:
- Macro: MINMAX_REDUCE_INDEX_EN.
- Defined:
  - Adds output out_index [CNT_W-1:0]: the zero-based position of the element currently held in acc.
  - Loaded as 0 in FIRST and updated to the element position whenever acc is replaced.
  - Ties keep the earlier index. Reset value 0; value 0 when out_empty = 1.
  - Held stable with out_result.
- Not defined: the port and its index counter are absent. All other behaviour is identical.

Test Plan:
- Unsigned max: len = 4, control = 1, sign_control = 0, stream 5, 0xFFFFFFFF, 7, 2 back-to-back -> out_valid 1 cycle after 4th beat, out_result = 0xFFFFFFFF (index 1 with MINMAX_REDUCE_INDEX_EN).
- Signed min with input stalls: len = 3, control = 0, sign_control = 1, stream 3, 0xFFFFFFFE (-2), -2, with in_valid low for 2 cycles between beats -> out_result = 0xFFFFFFFE; tie keeps the first -2, index 1.
- len = 0: start with len = 0 -> out_valid next cycle, out_result = 0, out_empty = 1, in_ready never asserted.
- Output backpressure: len = 1, element 0x80000000, out_ready held low 5 cycles -> out_valid and out_result = 0x80000000 stable all 5 cycles; start pulsed during DONE is ignored; IDLE and busy = 0 after the out_ready handshake.
- Reset mid-operation: len = 8, accept 3 beats, assert rst 1 cycle -> all outputs return to reset values next edge and no out_valid; a fresh start with len = 2, stream 9, 4 in max unsigned mode -> out_result = 9.
